// File: rtl/free_list_mp_if.sv
// Rename-stage free-list bundle: dispatch allocation, retire returns, checkpoint control.
// Master = rename/retire/branch-stack side, slave = free list.
interface free_list_mp_if #(
  parameter int NUM_PHYS_REG   = 64,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int NUM_CKPT       = 4
) ();
  localparam int TAG_W = $clog2(NUM_PHYS_REG);
  localparam int PTR_W = TAG_W + 1;
  localparam int ID_W  = $clog2(NUM_CKPT);

  // Handshake: dispatch_req (contiguous from slot 0) is the valid, alloc_ok is the
  // ready; tags in alloc_tag are consumed only on a cycle where both are high.
  // retire_valid is push-only with no back-pressure; drops are flagged via *_err.
  logic [DISPATCH_WIDTH-1:0]            dispatch_req;
  logic [DISPATCH_WIDTH-1:0][TAG_W-1:0] alloc_tag;
  logic                                 alloc_ok;
  logic [RETIRE_WIDTH-1:0]              retire_valid;
  logic [RETIRE_WIDTH-1:0][TAG_W-1:0]   retire_tag;
  logic                                 ckpt_save;
  logic [ID_W-1:0]                      ckpt_id;
  logic                                 restore;
  logic [ID_W-1:0]                      restore_id;
  logic [PTR_W-1:0]                     num_free;
  logic                                 empty;
  logic                                 overflow_err;
  logic                                 dup_err;

  modport master (
    output dispatch_req, retire_valid, retire_tag, ckpt_save, ckpt_id, restore, restore_id,
    input  alloc_tag, alloc_ok, num_free, empty, overflow_err, dup_err
  );

  modport slave (
    input  dispatch_req, retire_valid, retire_tag, ckpt_save, ckpt_id, restore, restore_id,
    output alloc_tag, alloc_ok, num_free, empty, overflow_err, dup_err
  );
endinterface

// File: rtl/free_list_mp.sv
// Superscalar checkpointed physical-register free list (circular buffer, wrap-bit pointers).
// Optional duplicate-free detection is enabled by defining FREE_LIST_DUP_CHECK_EN.
module free_list_mp #(
  parameter int NUM_PHYS_REG   = 64,
  parameter int NUM_ARCH_REG   = 32,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int NUM_CKPT       = 4
) (
  input logic           clock,
  input logic           reset,
  free_list_mp_if.slave fl
);
  localparam int TAG_W     = $clog2(NUM_PHYS_REG);
  localparam int PTR_W     = TAG_W + 1;
  localparam int INIT_FREE = NUM_PHYS_REG - NUM_ARCH_REG;

  logic [TAG_W-1:0]        entry_q [NUM_PHYS_REG];
  logic [TAG_W-1:0]        entry_d [NUM_PHYS_REG];
  logic [PTR_W-1:0]        ckpt_q  [NUM_CKPT];
  logic [PTR_W-1:0]        head_q, tail_q, num_free_q;
  logic [PTR_W-1:0]        head_d, tail_d, num_free_d, head_alloc;
  logic [PTR_W-1:0]        alloc_cnt, push_cnt;
  logic [RETIRE_WIDTH-1:0] accept;
  logic                    alloc_ok, push_ok, overflow_hit, dup_hit;
  logic                    overflow_q, dup_q;

  always_comb begin : alloc_logic
    logic [PTR_W-1:0] rd_ptr;
    rd_ptr    = '0;
    alloc_cnt = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc_cnt = alloc_cnt + PTR_W'(fl.dispatch_req[i]);
      rd_ptr    = head_q + PTR_W'(i);
      fl.alloc_tag[i] = entry_q[rd_ptr[TAG_W-1:0]];
    end
    alloc_ok   = !fl.restore && (num_free_q >= alloc_cnt);
    head_alloc = alloc_ok ? head_q + alloc_cnt : head_q;
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PHYS_REG-1:0] map_q, map_d;

  // A tag counts as already free if marked in the map or returned by an earlier slot.
  always_comb begin : dup_filter
    logic [NUM_PHYS_REG-1:0] seen;
    seen    = map_q;
    accept  = '0;
    dup_hit = 1'b0;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      if (fl.retire_valid[i]) begin
        if (seen[fl.retire_tag[i]]) begin
          dup_hit = 1'b1;
        end else begin
          accept[i]            = 1'b1;
          seen[fl.retire_tag[i]] = 1'b1;
        end
      end
    end
  end
`else
  assign accept  = fl.retire_valid;
  assign dup_hit = 1'b0;
`endif

  always_comb begin : push_logic
    logic [PTR_W-1:0] wr_ptr;
    push_cnt = '0;
    for (int i = 0; i < RETIRE_WIDTH; i++) push_cnt = push_cnt + PTR_W'(accept[i]);
    push_ok      = ({1'b0, num_free_q} + {1'b0, push_cnt}) <= (PTR_W + 1)'(NUM_PHYS_REG);
    overflow_hit = !push_ok;
    entry_d      = entry_q;
    wr_ptr       = tail_q;
    if (push_ok) begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (accept[i]) begin
          entry_d[wr_ptr[TAG_W-1:0]] = fl.retire_tag[i];
          wr_ptr = wr_ptr + PTR_W'(1);
        end
      end
    end
    tail_d     = wr_ptr;
    head_d     = fl.restore ? ckpt_q[fl.restore_id] : head_alloc;
    num_free_d = tail_d - head_d;
  end

`ifdef FREE_LIST_DUP_CHECK_EN
  // On restore the map is rebuilt from the live window head_d..tail_d of the new entries.
  always_comb begin : map_next
    logic [TAG_W-1:0] dist;
    dist  = '0;
    map_d = map_q;
    if (fl.restore) begin
      map_d = '0;
      for (int j = 0; j < NUM_PHYS_REG; j++) begin
        dist = TAG_W'(j) - head_d[TAG_W-1:0];
        if ({1'b0, dist} < num_free_d) map_d[entry_d[j]] = 1'b1;
      end
    end else begin
      if (alloc_ok) begin
        for (int i = 0; i < DISPATCH_WIDTH; i++)
          if (fl.dispatch_req[i]) map_d[fl.alloc_tag[i]] = 1'b0;
      end
      if (push_ok) begin
        for (int i = 0; i < RETIRE_WIDTH; i++)
          if (accept[i]) map_d[fl.retire_tag[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PHYS_REG; i++) map_q[i] <= (i >= NUM_ARCH_REG);
    end else begin
      map_q <= map_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PHYS_REG; i++)
        entry_q[i] <= (i < INIT_FREE) ? TAG_W'(NUM_ARCH_REG + i) : '0;
      for (int c = 0; c < NUM_CKPT; c++) ckpt_q[c] <= '0;
      head_q     <= '0;
      tail_q     <= PTR_W'(INIT_FREE);
      num_free_q <= PTR_W'(INIT_FREE);
      overflow_q <= 1'b0;
      dup_q      <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      num_free_q <= num_free_d;
      overflow_q <= overflow_q | overflow_hit;
      dup_q      <= dup_q | dup_hit;
      // A restore in the same cycle takes priority over a save.
      if (fl.ckpt_save && !fl.restore) ckpt_q[fl.ckpt_id] <= head_alloc;
    end
  end

  assign fl.alloc_ok     = alloc_ok;
  assign fl.num_free     = num_free_q;
  assign fl.empty        = (num_free_q == '0);
  assign fl.overflow_err = overflow_q;
  assign fl.dup_err      = dup_q;
endmodule

// File: tb/tb_free_list_mp.sv
// Directed bench for free_list_mp: allocation, retire, wrap-around, checkpoints, error flags.
module tb_free_list_mp;
  localparam int N = 64, A = 32, DW = 2, RW = 2, NC = 4, TAG_W = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [TAG_W-1:0] exp_q[$];

  always #5 clock = ~clock;

  free_list_mp_if #(.NUM_PHYS_REG(N), .DISPATCH_WIDTH(DW), .RETIRE_WIDTH(RW), .NUM_CKPT(NC)) fl ();

  free_list_mp #(
    .NUM_PHYS_REG(N), .NUM_ARCH_REG(A), .DISPATCH_WIDTH(DW), .RETIRE_WIDTH(RW), .NUM_CKPT(NC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fl   (fl.slave)
  );

  task automatic clear_inputs();
    fl.dispatch_req = '0;
    fl.retire_valid = '0;
    fl.retire_tag   = '0;
    fl.ckpt_save    = 1'b0;
    fl.ckpt_id      = '0;
    fl.restore      = 1'b0;
    fl.restore_id   = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    fl.dispatch_req = 2'b11;
    #1;
    n_checks++; if (fl.num_free !== 7'd32) $display("FAIL reset_num_free: got %0d want 32", fl.num_free); else n_pass++;
    n_checks++; if (fl.empty !== 1'b0) $display("FAIL reset_empty: got %b want 0", fl.empty); else n_pass++;
    n_checks++; if (fl.alloc_ok !== 1'b1) $display("FAIL reset_alloc_ok: got %b want 1", fl.alloc_ok); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd32) $display("FAIL reset_tag0: got %0d want 32", fl.alloc_tag[0]); else n_pass++;
    n_checks++; if (fl.alloc_tag[1] !== 6'd33) $display("FAIL reset_tag1: got %0d want 33", fl.alloc_tag[1]); else n_pass++;
    n_checks++; if (fl.overflow_err !== 1'b0 || fl.dup_err !== 1'b0) $display("FAIL reset_errs: got ovf=%b dup=%b want 0 0", fl.overflow_err, fl.dup_err); else n_pass++;
    fl.dispatch_req = '0;
  endtask

  // Continues from reset: drains all 32 free tags, then stalls on empty.
  task automatic test_drain();
    logic [TAG_W-1:0] e;
    for (int k = 0; k < 32; k++) exp_q.push_back(TAG_W'(32 + k));
    for (int c = 0; c < 16; c++) begin
      fl.dispatch_req = 2'b11;
      #1;
      n_checks++; if (fl.alloc_ok !== 1'b1) $display("FAIL drain_ok[%0d]: got %b want 1", c, fl.alloc_ok); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (fl.alloc_tag[0] !== e) $display("FAIL drain_tag0[%0d]: got %0d want %0d", c, fl.alloc_tag[0], e); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (fl.alloc_tag[1] !== e) $display("FAIL drain_tag1[%0d]: got %0d want %0d", c, fl.alloc_tag[1], e); else n_pass++;
      tick();
    end
    n_checks++; if (fl.num_free !== 7'd0) $display("FAIL drain_num_free: got %0d want 0", fl.num_free); else n_pass++;
    n_checks++; if (fl.empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", fl.empty); else n_pass++;
    n_checks++; if (fl.alloc_ok !== 1'b0) $display("FAIL drain_alloc_ok: got %b want 0", fl.alloc_ok); else n_pass++;
    tick();
    n_checks++; if (fl.num_free !== 7'd0) $display("FAIL stall_num_free: got %0d want 0", fl.num_free); else n_pass++;
    fl.dispatch_req = '0;
  endtask

  // Continues from the drained state; slot 1 only, so the tag must be compacted to tail.
  task automatic test_retire_from_empty();
    fl.dispatch_req    = 2'b01;
    fl.retire_valid    = 2'b10;
    fl.retire_tag[0]   = 6'd9;
    fl.retire_tag[1]   = 6'd5;
    #1;
    n_checks++; if (fl.alloc_ok !== 1'b0) $display("FAIL empty_retire_ok: got %b want 0", fl.alloc_ok); else n_pass++;
    tick();
    clear_inputs();
    fl.dispatch_req = 2'b11;
    #1;
    n_checks++; if (fl.num_free !== 7'd1) $display("FAIL retire_num_free: got %0d want 1", fl.num_free); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd5) $display("FAIL retire_tag0: got %0d want 5", fl.alloc_tag[0]); else n_pass++;
    n_checks++; if (fl.alloc_ok !== 1'b0) $display("FAIL retire_ok_two: got %b want 0", fl.alloc_ok); else n_pass++;
    fl.dispatch_req = 2'b01;
    #1;
    n_checks++; if (fl.alloc_ok !== 1'b1) $display("FAIL retire_ok_one: got %b want 1", fl.alloc_ok); else n_pass++;
    tick();
    fl.dispatch_req = '0;
    n_checks++; if (fl.num_free !== 7'd0) $display("FAIL retire_drained: got %0d want 0", fl.num_free); else n_pass++;
  endtask

  // Positions tail at entry 63 so the next two returns straddle entries 63 and 0.
  task automatic test_wrap();
    apply_reset();
    fl.dispatch_req = 2'b11;
    repeat (16) tick();
    fl.dispatch_req = '0;
    for (int c = 0; c < 15; c++) begin
      fl.retire_valid  = 2'b11;
      fl.retire_tag[0] = TAG_W'(32 + 2 * c);
      fl.retire_tag[1] = TAG_W'(33 + 2 * c);
      tick();
    end
    fl.retire_valid  = 2'b01;
    fl.retire_tag[0] = 6'd62;
    tick();
    fl.retire_valid = '0;
    n_checks++; if (fl.num_free !== 7'd31) $display("FAIL wrap_refill: got %0d want 31", fl.num_free); else n_pass++;
    fl.dispatch_req = 2'b11;
    repeat (15) tick();
    fl.dispatch_req = 2'b01;
    tick();
    fl.dispatch_req  = '0;
    fl.retire_valid  = 2'b11;
    fl.retire_tag[0] = 6'd1;
    fl.retire_tag[1] = 6'd2;
    tick();
    fl.retire_valid = '0;
    n_checks++; if (fl.num_free !== 7'd2) $display("FAIL wrap_num_free: got %0d want 2", fl.num_free); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd1) $display("FAIL wrap_tag0: got %0d want 1", fl.alloc_tag[0]); else n_pass++;
    n_checks++; if (fl.alloc_tag[1] !== 6'd2) $display("FAIL wrap_tag1: got %0d want 2", fl.alloc_tag[1]); else n_pass++;
    fl.dispatch_req  = 2'b11;
    fl.retire_valid  = 2'b01;
    fl.retire_tag[0] = 6'd3;
    #1;
    n_checks++; if (fl.alloc_ok !== 1'b1) $display("FAIL wrap_alloc_ok: got %b want 1", fl.alloc_ok); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (fl.num_free !== 7'd1) $display("FAIL both_num_free: got %0d want 1", fl.num_free); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd3) $display("FAIL both_tag0: got %0d want 3", fl.alloc_tag[0]); else n_pass++;
  endtask

  task automatic test_ckpt();
    apply_reset();
    fl.ckpt_save    = 1'b1;
    fl.ckpt_id      = 2'd2;
    fl.dispatch_req = 2'b01;
    #1;
    n_checks++; if (fl.alloc_tag[0] !== 6'd32) $display("FAIL ckpt_tag: got %0d want 32", fl.alloc_tag[0]); else n_pass++;
    tick();
    fl.ckpt_save    = 1'b0;
    fl.dispatch_req = 2'b11;
    #1;
    n_checks++; if (fl.alloc_tag[0] !== 6'd33) $display("FAIL ckpt_alloc_tag: got %0d want 33", fl.alloc_tag[0]); else n_pass++;
    repeat (2) tick();
    fl.dispatch_req = '0;
    n_checks++; if (fl.num_free !== 7'd27) $display("FAIL ckpt_pre_num_free: got %0d want 27", fl.num_free); else n_pass++;
    // Restore with a retire, an allocation request and a competing save all in one cycle.
    fl.restore       = 1'b1;
    fl.restore_id    = 2'd2;
    fl.retire_valid  = 2'b01;
    fl.retire_tag[0] = 6'd7;
    fl.dispatch_req  = 2'b11;
    fl.ckpt_save     = 1'b1;
    fl.ckpt_id       = 2'd2;
    #1;
    n_checks++; if (fl.alloc_ok !== 1'b0) $display("FAIL restore_alloc_ok: got %b want 0", fl.alloc_ok); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (fl.num_free !== 7'd32) $display("FAIL restore_num_free: got %0d want 32", fl.num_free); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd33) $display("FAIL restore_tag0: got %0d want 33", fl.alloc_tag[0]); else n_pass++;
    fl.dispatch_req = 2'b11;
    tick();
    fl.dispatch_req = '0;
    fl.restore      = 1'b1;
    fl.restore_id   = 2'd2;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (fl.num_free !== 7'd32) $display("FAIL save_ignored_num_free: got %0d want 32", fl.num_free); else n_pass++;
    n_checks++; if (fl.alloc_tag[0] !== 6'd33) $display("FAIL save_ignored_tag0: got %0d want 33", fl.alloc_tag[0]); else n_pass++;
  endtask

  task automatic test_dup();
    apply_reset();
    fl.retire_valid  = 2'b01;
    fl.retire_tag[0] = 6'd40;
    tick();
    clear_inputs();
    #1;
`ifdef FREE_LIST_DUP_CHECK_EN
    n_checks++; if (fl.num_free !== 7'd32) $display("FAIL dup_num_free: got %0d want 32", fl.num_free); else n_pass++;
    n_checks++; if (fl.dup_err !== 1'b1) $display("FAIL dup_err: got %b want 1", fl.dup_err); else n_pass++;
`else
    n_checks++; if (fl.num_free !== 7'd33) $display("FAIL dup_num_free: got %0d want 33", fl.num_free); else n_pass++;
    n_checks++; if (fl.dup_err !== 1'b0) $display("FAIL dup_err: got %b want 0", fl.dup_err); else n_pass++;
`endif
  endtask

  // Fills to 64 free (full, wrap bits differ) and then pushes one more tag.
  task automatic test_overflow();
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      fl.retire_valid  = 2'b11;
      fl.retire_tag[0] = TAG_W'(2 * c);
      fl.retire_tag[1] = TAG_W'(2 * c + 1);
      tick();
    end
    clear_inputs();
    #1;
    n_checks++; if (fl.num_free !== 7'd64) $display("FAIL full_num_free: got %0d want 64", fl.num_free); else n_pass++;
    n_checks++; if (fl.empty !== 1'b0) $display("FAIL full_empty: got %b want 0", fl.empty); else n_pass++;
    n_checks++; if (fl.overflow_err !== 1'b0) $display("FAIL full_overflow: got %b want 0", fl.overflow_err); else n_pass++;
    fl.retire_valid  = 2'b01;
    fl.retire_tag[0] = 6'd40;
    tick();
    clear_inputs();
    tick();
    n_checks++; if (fl.num_free !== 7'd64) $display("FAIL ovf_num_free: got %0d want 64", fl.num_free); else n_pass++;
`ifdef FREE_LIST_DUP_CHECK_EN
    n_checks++; if (fl.dup_err !== 1'b1 || fl.overflow_err !== 1'b0) $display("FAIL ovf_flags: got dup=%b ovf=%b want 1 0", fl.dup_err, fl.overflow_err); else n_pass++;
`else
    n_checks++; if (fl.overflow_err !== 1'b1 || fl.dup_err !== 1'b0) $display("FAIL ovf_flags: got ovf=%b dup=%b want 1 0", fl.overflow_err, fl.dup_err); else n_pass++;
`endif
    apply_reset();
    n_checks++; if (fl.overflow_err !== 1'b0 || fl.num_free !== 7'd32) $display("FAIL rereset: got ovf=%b num_free=%0d want 0 32", fl.overflow_err, fl.num_free); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_retire_from_empty();
    test_wrap();
    test_ckpt();
    test_dup();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1);
  end
endmodule
